camellia_cbc_ctrl: RTL and testbench

Upstream sequencer for the Camellia core. It accepts key/IV configuration and a valid/ready stream of 128-bit blocks, and drives the core's Krdy/Drdy/Kin/Din/EncDec pins. It waits on Kvld/Dvld and applies CBC chaining XOR around the core, in either direction. Results go out on a valid/ready stream; one block is in flight at a time.

---
 rtl/camellia_ctrl_pkg.sv | 20 ++
 rtl/camellia_cbc_chain.sv | 39 +++
 rtl/camellia_cbc_ctrl.sv | 144 ++++++++++++++
 tb/tb_camellia_cbc_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camellia_ctrl_pkg.sv
// Shared types and constants for the Camellia CBC/ECB sequencer.
package camellia_ctrl_pkg;

  localparam int BLK_W = 128;

  // Direction encoding matches the core's EncDec pin.
  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_NOKEY,
    ST_KREQ,
    ST_KWAIT,
    ST_READY,
    ST_DREQ,
    ST_DWAIT,
    ST_OUT
  } state_t;

endpackage

// File: rtl/camellia_cbc_chain.sv
// Chaining register with the pre-core and post-core XOR paths for CBC,
// transparent in ECB.
module camellia_cbc_chain
  import camellia_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_iv,
  input  logic [BLK_W-1:0] iv,
  input  logic             update,
  input  logic             cbc,
  input  logic             encdec,
  input  logic [BLK_W-1:0] blk_in,
  input  logic [BLK_W-1:0] dout,
  output logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] result
);

  logic [BLK_W-1:0] chain;

  // Encrypt chains on the ciphertext it produced; decrypt on the ciphertext it consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else if (load_iv) begin
      chain <= iv;
    end else if (update && cbc) begin
      chain <= (encdec == ENC) ? dout : blk_in;
    end
  end

  always_comb begin
    din    = blk_in;
    result = dout;
    if (cbc && encdec == ENC) din    = blk_in ^ chain;
    if (cbc && encdec == DEC) result = dout ^ chain;
  end

endmodule

// File: rtl/camellia_cbc_ctrl.sv
// Sequencer for the Camellia core: key setup, one block in flight, CBC/ECB
// chaining, and a watchdog on the core's Kvld/Dvld strobes.
//
// state    | meaning
// NOKEY    | no valid key schedule in the core
// KREQ     | Krdy strobe to the core
// KWAIT    | waiting for Kvld (watchdog running)
// READY    | key valid, accepting a block or a new cfg_load
// DREQ     | Drdy strobe with the pre-XORed block
// DWAIT    | waiting for Dvld (watchdog running)
// OUT      | result held on m_data until m_ready
module camellia_cbc_ctrl
  import camellia_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CW          = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cfg_load,
  input  logic [BLK_W-1:0] cfg_key,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic             cfg_encdec,
  input  logic             cfg_cbc,
  output logic             cfg_ready,
  output logic             err_timeout,
  input  logic [BLK_W-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [BLK_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             core_EN,
  output logic [BLK_W-1:0] core_Kin,
  output logic             core_Krdy,
  output logic [BLK_W-1:0] core_Din,
  output logic             core_Drdy,
  output logic             core_EncDec,
  input  logic [BLK_W-1:0] core_Dout,
  input  logic             core_Dvld,
  input  logic             core_Kvld,
  input  logic             core_BSY
);

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [BLK_W-1:0] key_q, s_q, m_q, din, result;
  logic             encdec_q, cbc_q, err_q;
  logic [CW-1:0]    tmo_cnt;
  logic             cfg_take, s_fire, d_done, tmo_hit, waiting;

  // Busy is informational only; sequencing relies on the strobes.
  logic unused_bsy;
  assign unused_bsy = core_BSY;

  assign cfg_take = cfg_load && (state == ST_NOKEY || state == ST_READY);
  assign s_ready  = (state == ST_READY) && !cfg_load;
  assign s_fire   = s_valid && s_ready;
  assign d_done   = (state == ST_DWAIT) && core_Dvld;
  assign waiting  = (state == ST_KWAIT) || (state == ST_DWAIT);

  // A strobe landing on the last count still wins over the abort.
  assign tmo_hit = (tmo_cnt == TMO_LAST) &&
                   ((state == ST_KWAIT && !core_Kvld) ||
                    (state == ST_DWAIT && !core_Dvld));

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_NOKEY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_NOKEY: if (cfg_take) state_nxt = ST_KREQ;
      ST_KREQ:  state_nxt = ST_KWAIT;
      ST_KWAIT: begin
        if (core_Kvld)    state_nxt = ST_READY;
        else if (tmo_hit) state_nxt = ST_NOKEY;
      end
      ST_READY: begin
        if (cfg_take)    state_nxt = ST_KREQ;
        else if (s_fire) state_nxt = ST_DREQ;
      end
      ST_DREQ:  state_nxt = ST_DWAIT;
      ST_DWAIT: begin
        if (core_Dvld)    state_nxt = ST_OUT;
        else if (tmo_hit) state_nxt = ST_NOKEY;
      end
      ST_OUT:   if (m_ready) state_nxt = ST_READY;
      default:  state_nxt = ST_NOKEY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      key_q    <= '0;
      s_q      <= '0;
      m_q      <= '0;
      encdec_q <= 1'b0;
      cbc_q    <= 1'b0;
      err_q    <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      if (cfg_take) begin
        key_q    <= cfg_key;
        encdec_q <= cfg_encdec;
        cbc_q    <= cfg_cbc;
        err_q    <= 1'b0;
      end
      if (s_fire)  s_q   <= s_data;
      if (d_done)  m_q   <= result;
      if (tmo_hit) err_q <= 1'b1;
      tmo_cnt <= waiting ? tmo_cnt + 1'b1 : '0;
    end
  end

  camellia_cbc_chain u_chain (
    .clk     (CLK),
    .rst     (RST),
    .load_iv (cfg_take),
    .iv      (cfg_iv),
    .update  (d_done),
    .cbc     (cbc_q),
    .encdec  (encdec_q),
    .blk_in  (s_q),
    .dout    (core_Dout),
    .din     (din),
    .result  (result)
  );

  assign cfg_ready   = (state == ST_READY);
  assign err_timeout = err_q;
  assign m_valid     = (state == ST_OUT);
  assign m_data      = m_q;
  assign core_EN     = 1'b1;
  assign core_Kin    = key_q;
  assign core_Krdy   = (state == ST_KREQ);
  assign core_Din    = din;
  assign core_Drdy   = (state == ST_DREQ);
  assign core_EncDec = encdec_q;

endmodule

// File: tb/tb_camellia_cbc_ctrl.sv
// Directed bench for camellia_cbc_ctrl against a behavioural core stub.
module tb_camellia_cbc_ctrl;

  localparam int TMO  = 64;
  localparam int KLAT = 3;
  localparam int DLAT = 5;

  localparam logic [127:0] KEY  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT   = 128'h67673138549669730857065648eabe43;
  localparam logic [127:0] MASK = 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IV2  = 128'hdeadbeef_00112233_44556677_8899aabb;

  logic         CLK, RST;
  logic         cfg_load, cfg_encdec, cfg_cbc, cfg_ready, err_timeout;
  logic [127:0] cfg_key, cfg_iv, s_data, m_data;
  logic         s_valid, s_ready, m_valid, m_ready;
  logic         core_EN, core_Krdy, core_Drdy, core_EncDec, core_Dvld, core_Kvld, core_BSY;
  logic [127:0] core_Kin, core_Din, core_Dout;

  int total = 0;
  int bad   = 0;

  camellia_cbc_ctrl #(.TIMEOUT_CYC(TMO), .CW(7)) dut (
    .CLK(CLK), .RST(RST),
    .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_encdec(cfg_encdec), .cfg_cbc(cfg_cbc), .cfg_ready(cfg_ready),
    .err_timeout(err_timeout),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .core_EN(core_EN), .core_Kin(core_Kin), .core_Krdy(core_Krdy),
    .core_Din(core_Din), .core_Drdy(core_Drdy), .core_EncDec(core_EncDec),
    .core_Dout(core_Dout), .core_Dvld(core_Dvld), .core_Kvld(core_Kvld),
    .core_BSY(core_BSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Core stub: the reference vector pair maps exactly, anything else XORs a mask.
  function automatic logic [127:0] stub_cipher(input logic [127:0] x, input logic dec);
    if (!dec && x == PT) return CT;
    if (dec && x == CT)  return PT;
    return x ^ MASK;
  endfunction

  int           krdy_cnt = 0;
  int           drdy_cnt = 0;
  int           kcnt = 0;
  int           dcnt = 0;
  bit           dvld_en = 1'b1;
  logic [127:0] stub_key = '0;
  logic [127:0] last_din = '0;
  logic         stub_dec = 1'b0;

  initial begin
    core_Kvld = 1'b0;
    core_Dvld = 1'b0;
    core_Dout = '0;
  end

  assign core_BSY = (kcnt != 0) || (dcnt != 0);

  always @(posedge CLK) begin
    if (core_Krdy) begin
      krdy_cnt  <= krdy_cnt + 1;
      stub_key  <= core_Kin;
      kcnt      <= KLAT;
      core_Kvld <= 1'b0;
    end else if (kcnt != 0) begin
      kcnt      <= kcnt - 1;
      core_Kvld <= (kcnt == 1);
    end else begin
      core_Kvld <= 1'b0;
    end
    if (core_Drdy) begin
      drdy_cnt  <= drdy_cnt + 1;
      last_din  <= core_Din;
      stub_dec  <= core_EncDec;
      dcnt      <= DLAT;
      core_Dvld <= 1'b0;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        core_Dvld <= dvld_en;
        core_Dout <= stub_cipher(last_din, stub_dec);
      end else begin
        core_Dvld <= 1'b0;
      end
    end else begin
      core_Dvld <= 1'b0;
    end
  end

  task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv,
                        input logic ed, input logic cb, output bit ok);
    @(negedge CLK);
    cfg_key = k; cfg_iv = iv; cfg_encdec = ed; cfg_cbc = cb; cfg_load = 1'b1;
    @(negedge CLK);
    cfg_load = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cfg_ready) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic xfer(input logic [127:0] d, output logic [127:0] r, output bit ok);
    r = '0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (s_ready) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    if (!ok) return;
    s_data = d; s_valid = 1'b1;
    @(negedge CLK);
    s_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_valid) begin r = m_data; ok = 1'b1; break; end
      @(negedge CLK);
    end
    if (!ok) return;
    m_ready = 1'b1;
    @(negedge CLK);
    m_ready = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    total++; if (cfg_ready !== 1'b0)   begin bad++; $display("FAIL rst_cfg_ready got=%b exp=0", cfg_ready); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_timeout); end
    total++; if (s_ready !== 1'b0)     begin bad++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    total++; if (m_valid !== 1'b0)     begin bad++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== '0)        begin bad++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
    total++; if (core_EN !== 1'b1)     begin bad++; $display("FAIL rst_core_en got=%b exp=1", core_EN); end
    total++; if (core_Krdy !== 1'b0 || core_Drdy !== 1'b0)
      begin bad++; $display("FAIL rst_strobes got krdy=%b drdy=%b exp=0", core_Krdy, core_Drdy); end
    total++; if (core_Kin !== '0 || core_Din !== '0 || core_EncDec !== 1'b0)
      begin bad++; $display("FAIL rst_core_bus got kin=%h din=%h ed=%b exp=0", core_Kin, core_Din, core_EncDec); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_ecb;
    logic [127:0] r;
    bit ok;
    int k0, d0;
    k0 = krdy_cnt; d0 = drdy_cnt;
    do_cfg(KEY, '0, 1'b0, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL ecb_key_ready got=timeout exp=ready"); end
    total++; if (stub_key !== KEY) begin bad++; $display("FAIL ecb_kin got=%h exp=%h", stub_key, KEY); end
    xfer(PT, r, ok);
    total++; if (!ok || r !== CT) begin bad++; $display("FAIL ecb_enc got=%h exp=%h ok=%0d", r, CT, ok); end
    total++; if (krdy_cnt - k0 != 1) begin bad++; $display("FAIL ecb_krdy_pulses got=%0d exp=1", krdy_cnt - k0); end
    total++; if (drdy_cnt - d0 != 1) begin bad++; $display("FAIL ecb_drdy_pulses got=%0d exp=1", drdy_cnt - d0); end
    total++; if (last_din !== PT) begin bad++; $display("FAIL ecb_enc_din got=%h exp=%h", last_din, PT); end

    do_cfg(KEY, '0, 1'b1, 1'b0, ok);
    xfer(CT, r, ok);
    total++; if (!ok || r !== PT) begin bad++; $display("FAIL ecb_dec got=%h exp=%h ok=%0d", r, PT, ok); end
    total++; if (stub_dec !== 1'b1) begin bad++; $display("FAIL ecb_dec_encdec got=%b exp=1", stub_dec); end
  endtask

  task automatic test_cbc;
    logic [127:0] r, c2;
    bit ok;
    c2 = PT ^ CT ^ MASK;
    do_cfg(KEY, '0, 1'b0, 1'b1, ok);
    xfer(PT, r, ok);
    total++; if (!ok || r !== CT) begin bad++; $display("FAIL cbc_enc_b1 got=%h exp=%h", r, CT); end
    xfer(PT, r, ok);
    total++; if (last_din !== (PT ^ CT)) begin bad++; $display("FAIL cbc_enc_b2_din got=%h exp=%h", last_din, PT ^ CT); end
    total++; if (!ok || r !== c2) begin bad++; $display("FAIL cbc_enc_b2 got=%h exp=%h", r, c2); end

    do_cfg(KEY, '0, 1'b1, 1'b1, ok);
    xfer(CT, r, ok);
    total++; if (last_din !== CT) begin bad++; $display("FAIL cbc_dec_b1_din got=%h exp=%h", last_din, CT); end
    total++; if (!ok || r !== PT) begin bad++; $display("FAIL cbc_dec_b1 got=%h exp=%h", r, PT); end
    xfer(c2, r, ok);
    total++; if (!ok || r !== PT) begin bad++; $display("FAIL cbc_dec_b2 got=%h exp=%h", r, PT); end
  endtask

  task automatic test_backpressure;
    logic [127:0] held;
    bit ok;
    int d0;
    do_cfg(KEY, '0, 1'b0, 1'b0, ok);
    d0 = drdy_cnt;
    for (int i = 0; i < 50 && !s_ready; i++) @(negedge CLK);
    s_data = PT; s_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (m_valid) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL bp_m_valid got=timeout exp=valid"); end
    held = m_data;
    total++; if (held !== CT) begin bad++; $display("FAIL bp_data got=%h exp=%h", held, CT); end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      total++;
      if (m_valid !== 1'b1 || m_data !== held || s_ready !== 1'b0)
        begin bad++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h sr=%b exp v=1 d=%h sr=0", i, m_valid, m_data, s_ready, held); end
    end
    total++; if (drdy_cnt - d0 != 1) begin bad++; $display("FAIL bp_drdy got=%0d exp=1", drdy_cnt - d0); end
    s_valid = 1'b0; m_ready = 1'b1;
    @(negedge CLK);
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b0 || cfg_ready !== 1'b1)
      begin bad++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", m_valid, cfg_ready); end
  endtask

  task automatic test_timeout;
    bit ok;
    int k;
    do_cfg(KEY, '0, 1'b0, 1'b0, ok);
    dvld_en = 1'b0;
    for (int i = 0; i < 50 && !s_ready; i++) @(negedge CLK);
    s_data = PT; s_valid = 1'b1;
    @(negedge CLK);
    s_valid = 1'b0;
    total++; if (core_Drdy !== 1'b1) begin bad++; $display("FAIL tmo_drdy got=%b exp=1", core_Drdy); end
    @(posedge CLK);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      k++;
      @(negedge CLK);
      if (err_timeout) break;
    end
    total++; if (k != TMO || err_timeout !== 1'b1)
      begin bad++; $display("FAIL tmo_latency got=%0d err=%b exp=%0d err=1", k, err_timeout, TMO); end
    total++; if (cfg_ready !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0)
      begin bad++; $display("FAIL tmo_state got rdy=%b v=%b sr=%b exp 0", cfg_ready, m_valid, s_ready); end
    repeat (5) @(negedge CLK);
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", err_timeout); end
    dvld_en = 1'b1;
    do_cfg(KEY, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || err_timeout !== 1'b0)
      begin bad++; $display("FAIL tmo_clear got err=%b ok=%0d exp err=0 ok=1", err_timeout, ok); end
  endtask

  task automatic test_cfg_vs_svalid;
    bit ok;
    int k0, d0;
    k0 = krdy_cnt; d0 = drdy_cnt;
    @(negedge CLK);
    s_data = PT; s_valid = 1'b1;
    cfg_key = KEY2; cfg_iv = '0; cfg_encdec = 1'b0; cfg_cbc = 1'b0; cfg_load = 1'b1;
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL race_s_ready got=%b exp=0", s_ready); end
    @(negedge CLK);
    cfg_load = 1'b0; s_valid = 1'b0;
    total++; if (core_Krdy !== 1'b1) begin bad++; $display("FAIL race_krdy got=%b exp=1", core_Krdy); end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cfg_ready) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    total++; if (!ok || krdy_cnt - k0 != 1 || drdy_cnt - d0 != 0 || m_valid !== 1'b0)
      begin bad++; $display("FAIL race_consume got ok=%0d krdy=%0d drdy=%0d v=%b exp 1 1 0 0", ok, krdy_cnt - k0, drdy_cnt - d0, m_valid); end
    total++; if (stub_key !== KEY2) begin bad++; $display("FAIL race_newkey got=%h exp=%h", stub_key, KEY2); end
  endtask

  task automatic test_reset_mid;
    bit ok, seen;
    do_cfg(KEY2, IV2, 1'b1, 1'b1, ok);
    for (int i = 0; i < 50 && !s_ready; i++) @(negedge CLK);
    s_data = PT; s_valid = 1'b1;
    @(negedge CLK);
    s_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    total++; if (core_Kin !== '0 || core_Din !== '0 || core_EncDec !== 1'b0 || core_EN !== 1'b1)
      begin bad++; $display("FAIL mid_rst_core got kin=%h din=%h ed=%b en=%b exp 0 0 0 1", core_Kin, core_Din, core_EncDec, core_EN); end
    total++; if (m_data !== '0 || m_valid !== 1'b0 || cfg_ready !== 1'b0 || s_ready !== 1'b0 || core_Drdy !== 1'b0)
      begin bad++; $display("FAIL mid_rst_out got d=%h v=%b rdy=%b sr=%b drdy=%b exp 0", m_data, m_valid, cfg_ready, s_ready, core_Drdy); end
    RST = 1'b0;
    seen = 1'b0;
    repeat (DLAT + 5) begin
      @(negedge CLK);
      if (m_valid || cfg_ready || s_ready) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL mid_rst_late_dvld got=active exp=idle"); end
  endtask

  initial begin
    RST = 1'b1;
    cfg_load = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_encdec = 1'b0; cfg_cbc = 1'b0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    test_reset();
    test_ecb();
    test_cbc();
    test_backpressure();
    test_timeout();
    test_cfg_vs_svalid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=stuck exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
